// File: rtl/trng_word_scheduler.sv
// -----------------------------------------------------------------------------
// trng_word_scheduler
//
// Sits between the Von Neumann debiasing stage and the TRNG consumers.
// Gates the ring-oscillator entropy source and drops a warm-up run of
// debiased bits after every start. Packs the following valid bits MSB-first
// into WORD_W-bit words and hands each completed word to one requester under
// round-robin arbitration. Two online health tests run alongside:
//   - repetition run: RUN_LIMIT consecutive identical valid bits
//   - stall timeout : TIMEOUT consecutive cycles without bit_valid
// Either failure latches a fault and stops the source until err_clr.
//
// Ports
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   enable     in   run request from system control
//   err_clr    in   single-cycle pulse, clears the latched fault
//   bit_in     in   debiased bit
//   bit_valid  in   bit_in qualifier
//   req        in   [NREQ]   per-requester word request (level)
//   src_en     out  entropy source enable
//   gnt        out  [NREQ]   one-hot, one-cycle grant; data valid with it
//   data       out  [WORD_W] delivered word, held until the next grant
//   word_rdy   out  a complete word is waiting for a requester
//   error      out  latched health-test fault
// -----------------------------------------------------------------------------
module trng_word_scheduler #(
  parameter int NREQ      = 2,
  parameter int WORD_W    = 32,
  parameter int DISCARD   = 64,
  parameter int TIMEOUT   = 1024,
  parameter int RUN_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic [NREQ-1:0]   req,
  output logic              src_en,
  output logic [NREQ-1:0]   gnt,
  output logic [WORD_W-1:0] data,
  output logic              word_rdy,
  output logic              error
);

  // One bit counter serves both warm-up and word collection, so it is sized
  // for the larger of the two limits.
  localparam int BIT_MAX = (DISCARD > WORD_W) ? DISCARD : WORD_W;
  localparam int BCNT_W  = $clog2(BIT_MAX + 1);
  localparam int ICNT_W  = $clog2(TIMEOUT + 1);
  localparam int RCNT_W  = $clog2(RUN_LIMIT + 1);
  localparam int PTR_W   = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    COLLECT = 3'd2,
    READY   = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [BCNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [ICNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [RCNT_W-1:0]   run_cnt_reg, run_cnt_next;
  logic                last_bit_reg, last_bit_next;
  logic [WORD_W-1:0]   word_reg, word_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;

  logic                src_en_reg, src_en_next;
  logic [NREQ-1:0]     gnt_reg, gnt_next;
  logic [WORD_W-1:0]   data_reg, data_next;
  logic                word_rdy_reg, word_rdy_next;
  logic                error_reg, error_next;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first set req bit searching upward from ptr+1, wrapping.
  // ---------------------------------------------------------------------------
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    cand_idx;
  logic [NREQ-1:0]     grant_onehot;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_reg;
    cand_idx  = ptr_reg;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = PTR_W'((int'(ptr_reg) + k) % NREQ);
      if (!grant_any && req[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_any && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Health tests. The run test watches every valid bit while the source runs,
  // including bits dropped in READY; the stall test only while bits are wanted.
  // ---------------------------------------------------------------------------
  logic run_active, tmo_active, run_same, run_fail, tmo_fail, fault_hit;

  assign run_active = (state_reg == WARMUP) || (state_reg == COLLECT) || (state_reg == READY);
  assign tmo_active = (state_reg == WARMUP) || (state_reg == COLLECT);
  // A zero run count means no reference bit yet, so the first bit starts a run.
  assign run_same   = (run_cnt_reg != '0) && (bit_in == last_bit_reg);
  assign run_fail   = run_active && bit_valid && run_same &&
                      (run_cnt_reg == RCNT_W'(RUN_LIMIT - 1));
  assign tmo_fail   = tmo_active && !bit_valid &&
                      (idle_cnt_reg == ICNT_W'(TIMEOUT - 1));
  assign fault_hit  = run_fail || tmo_fail;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_next     = word_reg;
    ptr_next      = ptr_reg;
    gnt_next      = '0;
    data_next     = data_reg;

    idle_cnt_next = '0;
    if (tmo_active && !bit_valid) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end

    run_cnt_next  = run_cnt_reg;
    last_bit_next = last_bit_reg;
    if (run_active && bit_valid) begin
      run_cnt_next  = run_same ? run_cnt_reg + 1'b1 : RCNT_W'(1);
      last_bit_next = bit_in;
    end

    // Priority in the running states: fault, then enable=0, then bit/grant.
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next   = WARMUP;
          bit_cnt_next = '0;
        end
      end

      WARMUP: begin
        if (fault_hit) begin
          state_next = FAULT;
        end else if (!enable) begin
          state_next = IDLE;
        end else if (bit_valid) begin
          if (bit_cnt_reg == BCNT_W'(DISCARD - 1)) begin
            state_next   = COLLECT;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      COLLECT: begin
        if (fault_hit) begin
          state_next = FAULT;
        end else if (!enable) begin
          state_next = IDLE;
        end else if (bit_valid) begin
          word_next = {word_reg[WORD_W-2:0], bit_in};
          if (bit_cnt_reg == BCNT_W'(WORD_W - 1)) begin
            state_next   = READY;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      READY: begin
        if (fault_hit) begin
          state_next = FAULT;
        end else if (!enable) begin
          state_next = IDLE;
        end else if (grant_any) begin
          gnt_next     = grant_onehot;
          data_next    = word_reg;
          ptr_next     = grant_idx;
          state_next   = COLLECT;
          bit_cnt_next = '0;
        end
      end

      FAULT: begin
        if (err_clr) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Leaving the running states discards all progress.
    if ((state_next == IDLE) || (state_next == FAULT)) begin
      bit_cnt_next  = '0;
      idle_cnt_next = '0;
      run_cnt_next  = '0;
    end

    src_en_next   = (state_next == WARMUP) || (state_next == COLLECT) || (state_next == READY);
    word_rdy_next = (state_next == READY);
    error_next    = (state_next == FAULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      run_cnt_reg  <= '0;
      last_bit_reg <= 1'b0;
      word_reg     <= '0;
      ptr_reg      <= PTR_W'(NREQ - 1);
      src_en_reg   <= 1'b0;
      gnt_reg      <= '0;
      data_reg     <= '0;
      word_rdy_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      run_cnt_reg  <= run_cnt_next;
      last_bit_reg <= last_bit_next;
      word_reg     <= word_next;
      ptr_reg      <= ptr_next;
      src_en_reg   <= src_en_next;
      gnt_reg      <= gnt_next;
      data_reg     <= data_next;
      word_rdy_reg <= word_rdy_next;
      error_reg    <= error_next;
    end
  end

  assign src_en   = src_en_reg;
  assign gnt      = gnt_reg;
  assign data     = data_reg;
  assign word_rdy = word_rdy_reg;
  assign error    = error_reg;

endmodule

// File: doc/trng_word_scheduler.md
# trng_word_scheduler

Controller between the Von Neumann debiasing stage and the TRNG consumers. Gates the ring-oscillator entropy source and discards a warm-up run of debiased bits. Packs subsequent valid bits into words and hands each word to one of NREQ requesters under round-robin arbitration. Runs two online health checks and latches a fault, stopping the source, when either fails.

## Interface
- NREQ, 2: number of requesters (2..8)
- WORD_W, 32: bits per delivered word (8..64)
- DISCARD, 64: valid debiased bits dropped after each start (≥1)
- TIMEOUT, 1024: max clk cycles without bit_valid before fault (≥2)
- RUN_LIMIT, 32: consecutive identical valid bits that trigger fault (≥2)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  run request from system control
- err_clr  in  1  single-cycle pulse, clears latched fault
- bit_in  in  1  debiased bit from debiasing stage
- bit_valid  in  1  bit_in qualifier from debiasing stage
- req  in  NREQ  per-requester word request, level, held until granted
- src_en  out  1  entropy source (ring oscillator) enable
- gnt  out  NREQ  one-hot, one-cycle grant pulse; data valid when any bit high
- data  out  WORD_W  delivered random word
- word_rdy  out  1  a complete word is waiting for a requester
- error  out  1  latched health-test fault

## Operation
- States: IDLE, WARMUP, COLLECT, READY, FAULT. All outputs are registered.
- Reset: state IDLE, src_en=0, gnt=0, data=0, word_rdy=0, error=0, all counters 0, RR pointer = NREQ-1 (requester 0 has first priority).
- IDLE: src_en=0. enable=1 → WARMUP with bit, idle and run counters cleared.
- WARMUP: src_en=1. Counts valid bits and discards them. On the DISCARD-th valid bit → COLLECT with bit count 0.
- COLLECT: src_en=1. Each valid bit sets word <= {word[WORD_W-2:0], bit_in}. On the WORD_W-th valid bit → READY.
- READY: src_en=1, word_rdy=1. Valid bits are dropped from the word but still feed the run test. If req≠0, grant the first set req bit searching upward (with wrap) from pointer+1. Next cycle: gnt one-hot high for exactly 1 cycle, data=word, pointer=granted index, state COLLECT with bit count 0.
- data holds its last value after gnt falls. It is never cleared except by reset.
- Run test: active whenever src_en=1. Counts consecutive equal valid bits. When the count reaches RUN_LIMIT → FAULT.
- Timeout test: active in WARMUP and COLLECT only. The idle counter increments each cycle with bit_valid=0 and clears on bit_valid=1. When it reaches TIMEOUT → FAULT.
- FAULT: error=1, src_en=0, word_rdy=0, gnt=0. The partial or complete word is discarded.
- Leaving FAULT: err_clr=1 → IDLE with error=0; if enable is still 1, the block restarts via WARMUP. enable has no effect in FAULT.
- enable=0 in WARMUP/COLLECT/READY → IDLE next cycle. The word is discarded, no gnt is issued, and the counters are cleared.
- Simultaneous events: a fault condition outranks a pending grant and enable=0. enable=0 outranks a grant in the same cycle. A requester dropping req before gnt is legal and that requester receives nothing.
- Async reset mid-operation returns all outputs to reset values immediately. No word is delivered.

## Timing
- src_en rises 1 cycle after enable is sampled high in IDLE. It falls 1 cycle after FAULT entry or after enable is sampled low.
- Warm-up latency: DISCARD valid bits. After that, each word needs WORD_W valid bits.
- Last valid bit of a word at edge N: word_rdy=1 from edge N+1. If req is already high, gnt and data are present from edge N+2, one cycle wide.
- A valid bit in the gnt cycle is the first bit of the next word.
- Fault is entered on the edge after the detecting condition: the RUN_LIMIT-th equal bit, or the TIMEOUT-th idle cycle. error rises on that edge.
- Counter widths are $clog2(limit+1). No counter wraps, because each saturating condition forces a state change.

## Test plan
- Bring-up (WORD_W=8, DISCARD=4): enable=1, feed 4 valid bits then 1,0,1,1,0,0,1,0 with req=01 → gnt=01 for exactly 1 cycle, data=8'hB2. Warm-up bits must not appear in data.
- Round-robin: req=11 held across 3 words → grants 01, 10, 01. Then req=10 only → gnt=10.
- Timeout (TIMEOUT=16): in COLLECT, hold bit_valid=0 for 16 cycles → error=1, src_en=0 on the next edge, no gnt. Then err_clr → IDLE, error=0, and WARMUP restarts with enable high.
- Run test (RUN_LIMIT=6): feed alternating bits, then six consecutive 1s → FAULT after the 6th. Five 1s followed by a 0 must not fault.
- enable dropped in READY while req=01 in the same cycle → no gnt, IDLE, src_en=0. Re-enable → the full DISCARD warm-up repeats.
- Async rstn asserted during COLLECT → all outputs 0 immediately. After release, requester 0 has first priority.
